// File: rtl/inst_queue_if.sv
// IF/SRAM/ID handshake bundle for inst_queue; master = fetch/SRAM/decode side, slave = queue.
interface inst_queue_if #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned PC_W   = 32,
   parameter int unsigned INST_W = 32
);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic              req_valid;
   logic [PC_W-1:0]   req_pc;
   logic              req_ready;
   logic [INST_W-1:0] inst_sram_rdata;
   logic              flush;
   logic              id_valid;
   logic [PC_W-1:0]   id_pc;
   logic [INST_W-1:0] id_inst;
   logic              id_ready;
   logic [CNT_W-1:0]  count;

   modport master (
      output req_valid, req_pc, inst_sram_rdata, flush, id_ready,
      input  req_ready, id_valid, id_pc, id_inst, count
   );

   modport slave (
      input  req_valid, req_pc, inst_sram_rdata, flush, id_ready,
      output req_ready, id_valid, id_pc, id_inst, count
   );
endinterface

// File: rtl/inst_queue.sv
// Flushable IF->ID instruction queue pairing each fetch PC with next-cycle SRAM data.
// Define INST_QUEUE_BYPASS_EN to present a fresh response to ID in its arrival cycle when empty.
module inst_queue #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned PC_W   = 32,
   parameter int unsigned INST_W = 32
) (
   input logic         clk,
   input logic         rst,
   inst_queue_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [PC_W-1:0]   pc_mem   [DEPTH];
   logic [INST_W-1:0] inst_mem [DEPTH];

   logic [CNT_W-1:0] count_q;
   logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
   logic             pend_q;
   logic [PC_W-1:0]  pend_pc_q;

   logic [CNT_W:0] occ;
   logic           req_ready;
   logic           req_acc;
   logic           head_valid;
   logic           byp;
   logic           byp_take;
   logic           push;
   logic           pop;

   // A flush frees everything, so the branch-target fetch is never blocked.
   always_comb begin
      occ = {1'b0, count_q} + {{CNT_W{1'b0}}, pend_q};
      if (bus.flush) occ = '0;
   end

   assign req_ready  = ~rst & (occ < (CNT_W + 1)'(DEPTH));
   assign req_acc    = bus.req_valid & req_ready;
   assign head_valid = (count_q != '0);

`ifdef INST_QUEUE_BYPASS_EN
   assign byp = ~head_valid & pend_q & ~bus.flush & ~rst;
`else
   assign byp = 1'b0;
`endif

   assign byp_take = byp & bus.id_ready;
   assign push     = pend_q & ~bus.flush & ~rst & ~byp_take;
   assign pop      = head_valid & bus.id_ready;

   always_comb begin
      bus.id_valid = 1'b0;
      bus.id_pc    = '0;
      bus.id_inst  = '0;
      if (head_valid) begin
         bus.id_valid = 1'b1;
         bus.id_pc    = pc_mem[rd_ptr_q];
         bus.id_inst  = inst_mem[rd_ptr_q];
      end else if (byp) begin
         bus.id_valid = 1'b1;
         bus.id_pc    = pend_pc_q;
         bus.id_inst  = bus.inst_sram_rdata;
      end
   end

   assign bus.req_ready = req_ready;
   assign bus.count     = count_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q   <= '0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         pend_q    <= 1'b0;
         pend_pc_q <= '0;
      end else if (bus.flush) begin
         count_q  <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         pend_q   <= req_acc;
         if (req_acc) pend_pc_q <= bus.req_pc;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
         pend_q <= req_acc;
         if (req_acc) pend_pc_q <= bus.req_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr_q]   <= pend_pc_q;
         inst_mem[wr_ptr_q] <= bus.inst_sram_rdata;
      end
   end
endmodule

// File: doc/inst_queue.md
# inst_queue

Parametrised instruction queue between IF and ID. It pairs each fetch PC with the instruction word the instruction SRAM returns one cycle later, and buffers up to DEPTH {pc, inst} entries. ID can stall for any number of cycles without losing or misaligning instructions, and a branch flush discards everything older than the flush cycle. This replaces the single-register instruction hold in ID with a general, flushable, multi-entry buffer.

## Interface
- DEPTH, 4, number of entries; power of two, ≥2.
- PC_W, 32, PC width.
- INST_W, 32, instruction width.
- CNT_W, $clog2(DEPTH+1), occupancy counter width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  IF issues an instruction-SRAM read this cycle.
- req_pc  in  PC_W  PC of that read.
- req_ready  out  1  queue guarantees space for a read issued this cycle.
- inst_sram_rdata  in  INST_W  SRAM data for the read issued in the previous cycle.
- flush  in  1  branch redirect; drops queued and in-flight entries.
- id_valid  out  1  head entry is valid.
- id_pc  out  PC_W  PC of the head entry; 0 when id_valid=0.
- id_inst  out  INST_W  instruction of the head entry; 0 when id_valid=0.
- id_ready  in  1  ID consumes the head this cycle (ID not stalled).
- count  out  CNT_W  number of stored entries, excluding the in-flight read.

## Operation
- Storage: circular buffer of DEPTH entries, with rd_ptr and wr_ptr each $clog2(DEPTH) bits wide, wrapping modulo DEPTH. count is tracked separately, so full and empty are never ambiguous.
- In-flight tracker: pend_r and pend_pc_r. A request accepted at cycle N (req_valid & req_ready) sets pend_r=1 and pend_pc_r=req_pc at cycle N+1. At N+1 the entry {pend_pc_r, inst_sram_rdata} is pushed and pend_r then clears, unless a new request is accepted in that same cycle.
- req_ready = ~rst & ((count + pend_r) < DEPTH). It takes no credit for a pop in the same cycle. Without bypass, full throughput requires DEPTH≥3.
- Pop: id_valid & id_ready advances rd_ptr.
- Push and pop in the same cycle: the pointers advance and count is unchanged.
- Overflow cannot occur, because req_ready guarantees space. A push while count==DEPTH is a design error and is flagged by a bench assertion.
- Flush at cycle N has the following effects:
  - count, rd_ptr and wr_ptr clear to 0.
  - pend_r is ignored (the response arriving at N is dropped) and is cleared.
  - A pop at N has no effect beyond the clear.
  - A request accepted at N (the branch-target fetch) is kept: pend_r=1 at N+1. During a flush, req_ready evaluates as though count=0 and pend_r=0.
- Reset values: count=0, pointers=0, pend_r=0, id_valid=0, id_pc=0, id_inst=0. req_ready is 0 while rst=1 and 1 in the first cycle after release.
- Reset asserted mid-operation discards all entries and any in-flight response, identical to flush. A request presented during reset is not accepted.

## Timing
- Request at N, SRAM data at N+1, entry written at the N+1 edge.
- Without bypass, id_valid is asserted with that entry at N+2 at the earliest.
- Registered outputs: id_valid, id_pc and id_inst derive from registered state only, with no combinational path from req_* or inst_sram_rdata, unless bypass is enabled.
- id_ready affects state only at the clock edge. The head stays stable while id_valid=1 and id_ready=0.
- The effect of flush is visible in the cycle after assertion: id_valid=0 at N+1.

## Configuration
- INST_QUEUE_BYPASS_EN defined:
  - When count==0, pend_r=1 and no flush, the response is presented combinationally at N+1: id_valid=1, id_pc=pend_pc_r, id_inst=inst_sram_rdata.
  - If id_ready=1 in that cycle, the entry is consumed and not written. Otherwise it is written normally.
  - Result: one cycle lower latency, and DEPTH≥2 suffices for full throughput.
- Not defined: outputs are driven only from stored entries, giving the latency stated in Timing.

## Test plan
- Reset, then a single request with req_pc=0xBFC00000 and rdata 0x3C081234 at N+1, id_ready=1 → id_valid=1 with those values at N+2 (N+1 with bypass), then count=0.
- Back-to-back requests on PCs 0x0, 0x4, 0x8, … with id_ready=0 → req_ready falls when count+pend_r reaches 4 (DEPTH=4). Then raise id_ready → entries drain in PC order with no loss or duplication.
- Continuous fetch with id_ready toggling every cycle → every PC is paired with its own rdata, and the pointers wrap past DEPTH at least three times.
- Queue holding 3 entries plus one in flight, flush asserted together with a request to 0x00400100 → id_valid=0 at N+1. The next entry out is 0x00400100 with its rdata; the dropped response never appears.
- Push and pop in the same cycle with count=2 → count stays 2 and the head advances.
- rst asserted for one cycle with 2 entries stored and pend_r=1 → all outputs are zero, count=0, and the late response is not written.
